// File: rtl/spike_aer_streamer.sv
// Samples a spike vector on each time step and streams it out over AXI-Stream,
// either one beat per spike (AER) or one mask beat per neuron block (raster).
module spike_aer_streamer #(
    parameter int NB      = 4,
    parameter int N       = 16,
    parameter int TS_W    = 12,
    parameter int TDATA_W = 32,
    parameter int MODE    = 0,
    localparam int BW     = (NB > 1) ? $clog2(NB) : 1,
    localparam int NW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               time_step,
    input  logic [NB*N-1:0]    spikes,
    input  logic               force_spike_en,
    input  logic [BW-1:0]      force_spike_block_select,
    input  logic [NW-1:0]      force_spike_neuron_select,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               done,
    output logic [7:0]         overflow_cnt
);
    localparam int NBN   = NB * N;
    localparam int LOW_W = (MODE == 1) ? N : NW;

    generate
        if (TDATA_W < TS_W + BW + ((NW > N * MODE) ? NW : N * MODE) + 1) begin : g_width_check
            $error("spike_aer_streamer: TDATA_W too small for TS_W, block, neuron/mask and marker bit");
        end
    endgenerate

    // Handshake: a beat transfers on any cycle with m_axis_tvalid & m_axis_tready.
    // Once tvalid rises, tvalid/tdata/tlast hold until that transfer happens.
    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, MARK = 2'd2} state_t;
    state_t state, state_next;

    logic [NBN-1:0]  cap, pending, force_vec, cap_in;
    logic [TS_W-1:0] ts_ctr, ts_cur;
    logic [BW-1:0]   blk_idx, sel_b, blk_field;
    logic [NW-1:0]   sel_n;
    logic [N-1:0]    mask;
    logic [LOW_W-1:0] low_field;
    logic            aer_last, hs;
    int              force_idx;

    always_comb begin
        force_idx = int'(force_spike_block_select) * N + int'(force_spike_neuron_select);
        force_vec = '0;
        for (int i = 0; i < NBN; i++) begin
            force_vec[i] = force_spike_en && (force_idx == i);
        end
        cap_in = spikes | pending | force_vec;
    end

    // Lowest set bit of cap is the next AER beat; last loop hit wins.
    always_comb begin
        sel_b = '0;
        sel_n = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            for (int n = N - 1; n >= 0; n--) begin
                if (cap[b*N+n]) begin
                    sel_b = BW'(b);
                    sel_n = NW'(n);
                end
            end
        end
        mask = '0;
        for (int b = 0; b < NB; b++) begin
            if (blk_idx == BW'(b)) mask = cap[b*N +: N];
        end
        aer_last  = ((cap & (cap - NBN'(1))) == '0);
        low_field = (MODE == 1) ? LOW_W'(mask) : LOW_W'(sel_n);
        blk_field = (MODE == 1) ? blk_idx : sel_b;
    end

    assign hs = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (time_step) state_next = (MODE == 1 || cap_in != '0) ? EMIT : MARK;
            EMIT: if (hs && m_axis_tlast) state_next = IDLE;
            MARK: if (hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state)
            EMIT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (MODE == 1) ? (blk_idx == BW'(NB - 1)) : aer_last;
                m_axis_tdata[LOW_W-1:0]        = low_field;
                m_axis_tdata[LOW_W +: BW]      = blk_field;
                m_axis_tdata[LOW_W+BW +: TS_W] = ts_cur;
            end
            MARK: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata[TDATA_W-1] = 1'b1;
                m_axis_tdata[TS_W-1:0]  = ts_cur;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap          <= '0;
            pending      <= '0;
            ts_ctr       <= '0;
            ts_cur       <= '0;
            blk_idx      <= '0;
            overflow_cnt <= '0;
            done         <= 1'b0;
        end else begin
            done    <= 1'b0;
            pending <= pending | force_vec;
            if (time_step) begin
                ts_ctr <= ts_ctr + TS_W'(1);
                if (state == IDLE) begin
                    cap     <= cap_in;
                    pending <= '0;
                    ts_cur  <= ts_ctr;
                    blk_idx <= '0;
                end else if (overflow_cnt != 8'hff) begin
                    // Busy: the step is dropped but still consumes a timestamp.
                    overflow_cnt <= overflow_cnt + 8'd1;
                end
            end
            if (state == EMIT && hs) begin
                if (MODE == 1) blk_idx <= blk_idx + BW'(1);
                else           cap     <= cap & (cap - NBN'(1));
                if (m_axis_tlast) done <= 1'b1;
            end
            if (state == MARK && hs) done <= 1'b1;
        end
    end
endmodule
